// File: rtl/im_level_stream_if.sv
// Bundle of the item-memory write port, request channel and beat-stream output
// channel of im_level_stream. The slave modport is the block's view.
interface im_level_stream_if #(
    parameter int HV_W   = 64,
    parameter int LVL_W  = 4,
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    wr_en;
    logic [LVL_W-1:0]        wr_addr;
    logic [HV_W-1:0]         wr_data;
    logic                    req_valid;
    logic                    req_ready;
    logic [NUM_CH*LVL_W-1:0] req_lvl;
    logic                    out_valid;
    logic                    out_ready;
    logic [HV_W-1:0]         out_hv;
    logic [CH_W-1:0]         out_ch;
    logic                    out_last;
    logic                    out_err;
    logic                    busy;

    modport master (
        output wr_en, wr_addr, wr_data, req_valid, req_lvl, out_ready,
        input  req_ready, out_valid, out_hv, out_ch, out_last, out_err, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, req_valid, req_lvl, out_ready,
        output req_ready, out_valid, out_hv, out_ch, out_last, out_err, busy
    );
endinterface

// File: rtl/im_level_stream.sv
// Level item memory that streams one stored hypervector per channel level of a request.
// Optional macro IM_RANGE_CHECK_EN: flags beats whose level has no stored slot via out_err.
module im_level_stream #(
    parameter int HV_W    = 64,
    parameter int NUM_LVL = 10,
    parameter int LVL_W   = 4,
    parameter int NUM_CH  = 4
) (
    input  logic            clk,
    input  logic            nrst,
    im_level_stream_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                  state_q, state_d;
    logic [HV_W-1:0]         mem_q [NUM_LVL];
    logic [NUM_CH*LVL_W-1:0] lvl_q, lvl_d;
    logic                    out_valid_q, out_valid_d;
    logic [HV_W-1:0]         out_hv_q, out_hv_d;
    logic [CH_W-1:0]         out_ch_q, out_ch_d;
    logic                    out_last_q, out_last_d;
    logic                    ready_w, req_hs, beat_hs, load;
    logic [CH_W-1:0]         load_ch;
    logic [LVL_W-1:0]        load_lvl;
`ifdef IM_RANGE_CHECK_EN
    localparam logic [LVL_W:0] NUM_LVL_L = (LVL_W + 1)'(NUM_LVL);
    logic                    out_err_q, out_err_d;
`endif

    // Levels with no slot fall through the match loop and read as zero.
    function automatic logic [HV_W-1:0] fetch(input logic [LVL_W-1:0] lvl);
        logic [HV_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LVL; i++) begin
            if (lvl == LVL_W'(i)) r = mem_q[i];
        end
        return r;
    endfunction

    always_comb begin
        ready_w     = (state_q == IDLE) || (out_valid_q && bus.out_ready && out_last_q);
        req_hs      = bus.req_valid && ready_w;
        beat_hs     = out_valid_q && bus.out_ready;
        state_d     = state_q;
        lvl_d       = lvl_q;
        out_valid_d = out_valid_q;
        out_hv_d    = out_hv_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        load        = 1'b0;
        load_ch     = '0;
        load_lvl    = bus.req_lvl[LVL_W-1:0];
`ifdef IM_RANGE_CHECK_EN
        out_err_d   = out_err_q;
`endif
        if (req_hs) begin
            // A request accepted on the last beat chains straight into its channel 0.
            state_d  = STREAM;
            lvl_d    = bus.req_lvl;
            load     = 1'b1;
        end else if (beat_hs) begin
            if (out_last_q) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end else begin
                load     = 1'b1;
                load_ch  = out_ch_q + 1'b1;
                load_lvl = lvl_q[int'(load_ch)*LVL_W +: LVL_W];
            end
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_hv_d    = fetch(load_lvl);
            out_ch_d    = load_ch;
            out_last_d  = (load_ch == LAST_CH);
`ifdef IM_RANGE_CHECK_EN
            out_err_d   = ({1'b0, load_lvl} >= NUM_LVL_L);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            lvl_q       <= '0;
            out_valid_q <= 1'b0;
            out_hv_q    <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
`ifdef IM_RANGE_CHECK_EN
            out_err_q   <= 1'b0;
`endif
            for (int i = 0; i < NUM_LVL; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            out_valid_q <= out_valid_d;
            out_hv_q    <= out_hv_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
`ifdef IM_RANGE_CHECK_EN
            out_err_q   <= out_err_d;
`endif
            // Beat fetch above used pre-edge contents, so same-edge writes land after it.
            for (int i = 0; i < NUM_LVL; i++) begin
                if (bus.wr_en && bus.wr_addr == LVL_W'(i)) mem_q[i] <= bus.wr_data;
            end
        end
    end

    assign bus.req_ready = ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hv    = out_hv_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == STREAM);
`ifdef IM_RANGE_CHECK_EN
    assign bus.out_err   = out_err_q;
`else
    assign bus.out_err   = 1'b0;
`endif
endmodule

// File: doc/im_level_stream.md
IM_LEVEL_STREAM -- requirements
Module: im_level_stream

Interface
REQ-001 Parameter HV_W, default 64, hypervector width in bits.
REQ-002 Parameter NUM_LVL, default 10, number of stored level hypervectors.
REQ-003 Parameter LVL_W, default 4, quantized-level index width; SHALL satisfy 2**LVL_W >= NUM_LVL.
REQ-004 Parameter NUM_CH, default 4, number of channel levels per request; CH_W = max(1, clog2(NUM_CH)).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 nrst  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  1  item-memory write strobe.
REQ-008 wr_addr  input  LVL_W  level slot to write.
REQ-009 wr_data  input  HV_W  hypervector to store.
REQ-010 req_valid  input  1  request present.
REQ-011 req_ready  output  1  request accepted when high together with req_valid.
REQ-012 req_lvl  input  NUM_CH*LVL_W  packed levels; channel k at bits [k*LVL_W +: LVL_W].
REQ-013 out_valid  output  1  output beat present.
REQ-014 out_ready  input  1  downstream accepts beat.
REQ-015 out_hv  output  HV_W  fetched level hypervector.
REQ-016 out_ch  output  CH_W  channel index of current beat.
REQ-017 out_last  output  1  high on beat of channel NUM_CH-1.
REQ-018 out_err  output  1  beat level out of range (see Configuration).
REQ-019 busy  output  1  high in state STREAM.

Function
REQ-020 Storage SHALL be NUM_LVL registers of HV_W bits; wr_en with wr_addr < NUM_LVL writes wr_data at the clock edge; wr_addr >= NUM_LVL is ignored.
REQ-021 FSM states IDLE and STREAM; IDLE -> STREAM on request handshake; STREAM -> IDLE on handshake of last beat with no new request accepted.
REQ-022 req_ready SHALL be 1 in IDLE, and in STREAM only while out_valid && out_ready && out_last (back-to-back chaining); 0 otherwise.
REQ-023 On request handshake the block SHALL capture req_lvl and load channel 0 beat; out_valid rises the following cycle (latency 1).
REQ-024 Each out_valid && out_ready handshake on a non-last beat SHALL load the next channel beat the same edge; no bubble between beats.
REQ-025 While out_valid && !out_ready, out_hv, out_ch, out_last, out_err SHALL hold stable.
REQ-026 Beat data SHALL be read from storage at the edge the beat is loaded; a write to the same slot on that edge does not affect it (read-before-write); later beats see the new contents.
REQ-027 Level >= NUM_LVL SHALL produce out_hv = 0.
REQ-028 Last-beat handshake without new request: out_valid drops next cycle, out_* data hold last values.
REQ-029 NUM_CH = 1: every beat is last; out_ch = 0.

Reset
REQ-030 With nrst low at a clock edge: state IDLE, out_valid 0, out_hv 0, out_ch 0, out_last 0, out_err 0, busy 0, all storage slots 0, captured levels 0.
REQ-031 Reset mid-stream SHALL abort the request with no further beats; wr_en is ignored during reset.

Configuration
REQ-032 Macro IM_RANGE_CHECK_EN: when defined, out_err = 1 for any beat whose level >= NUM_LVL (out_hv still 0); when undefined, out_err is tied 0 and no comparison logic beyond REQ-027 exists.

Verification
REQ-033 Write slots 0..9 with 64'h1111..., 64'h2222..., ..., reset-free; request levels {3,0,9,1} (ch3..ch0), out_ready=1 -> beats ch0..ch3 carry slots 1,9,0,3 on four consecutive cycles, out_last on ch3 only, out_valid 1 cycle after accept.
REQ-034 Same request with out_ready low for 3 cycles on ch1 -> ch1 beat held unchanged 4 cycles, total 7 cycles valid, no beat lost or duplicated.
REQ-035 Request level 4'hC on ch2, IM_RANGE_CHECK_EN defined -> ch2 out_hv 0, out_err 1, other beats out_err 0; undefined -> out_hv 0, out_err 0.
REQ-036 Two requests back-to-back with req_valid held -> req_ready high on last beat handshake, 8 beats contiguous, busy never drops.
REQ-037 Write slot 5 = 64'hDEAD_BEEF_0000_0001 on the edge ch0 (level 5) loads -> ch0 shows old slot 5; later channel with level 5 shows new value.
REQ-038 Assert nrst low during ch2 beat -> next cycle out_valid 0, busy 0, req_ready 1, all slots read 0 on subsequent request.
